// File: rtl/uart_tx_fifo_if.sv
// Host byte-bus control lines shared by the podule peripherals.
// The bidirectional data bus D stays a plain inout port on the peripheral.
interface uart_tx_fifo_if;
  logic [13:0] A;
  logic        cs;
  logic        re;
  logic        we;

  modport master (output A, cs, re, we);
  modport slave  (input  A, cs, re, we);
endinterface

// File: rtl/uart_tx_fifo.sv
// Host-programmable 8N1 UART transmitter with a circular transmit FIFO and
// a level interrupt requested while the FIFO has room for more data.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 217,
  parameter int FIFO_AW    = 4,
  parameter int IRQ_THRESH = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  inout  wire  [7:0]    D,
  output logic          txd,
  output logic          uart_tx_irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;
  localparam int CW    = $clog2(CLK_DIV);
  localparam logic [CW-1:0]    DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(IRQ_THRESH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic [7:0]           shift_reg, shift_next;
  logic                 txd_reg, txd_next;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 overflow_reg, irq_en_reg, irq_reg, wr_prev_reg;
  logic                 wr_strobe, wr_pulse, data_wr, ctrl_wr, soft_rst;
  logic                 push, pop, empty, full, busy;
  logic [1:0]           addr;
  logic [7:0]           rd_data;
  logic                 unused_addr;

  assign addr        = bus.A[3:2];
  assign unused_addr = ^{bus.A[13:4], bus.A[1:0]};
  assign wr_strobe   = bus.cs && bus.we;
  // A held strobe acts once: only its first sampled edge counts.
  assign wr_pulse    = wr_strobe && !wr_prev_reg;
  assign data_wr     = wr_pulse && (addr == 2'b00);
  assign ctrl_wr     = wr_pulse && (addr == 2'b01);
  assign soft_rst    = wr_pulse && (addr == 2'b11);

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_C);
  assign push  = data_wr && !full;
  assign busy  = (state_reg != IDLE);

  assign txd         = txd_reg;
  assign uart_tx_irq = irq_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_prev_reg  <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      irq_en_reg   <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      wr_prev_reg <= wr_strobe;
      if (soft_rst) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
        if (push && !pop) begin
          count_reg <= count_reg + CNT_W'(1);
        end else if (pop && !push) begin
          count_reg <= count_reg - CNT_W'(1);
        end
        if (data_wr && full) begin
          overflow_reg <= 1'b1;
        end else if (ctrl_wr && D[0]) begin
          overflow_reg <= 1'b0;
        end
      end
      if (ctrl_wr) irq_en_reg <= D[7];
      irq_reg <= irq_en_reg && (count_reg < THRESH_C);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      txd_reg     <= 1'b1;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      txd_reg     <= txd_next;
    end
  end

  // txd is registered; each branch sets the level for the period it starts.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    txd_next     = txd_reg;
    pop          = 1'b0;
    if (soft_rst) begin
      state_next = IDLE;
      txd_next   = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          txd_next = 1'b1;
          if (!empty) begin
            pop          = 1'b1;
            shift_next   = mem[rd_ptr_reg];
            bit_cnt_next = DIV_LAST;
            txd_next     = 1'b0;
            state_next   = START;
          end
        end
        START: begin
          if (bit_cnt_reg == '0) begin
            bit_cnt_next = DIV_LAST;
            bit_idx_next = 3'd0;
            txd_next     = shift_reg[0];
            state_next   = DATA;
          end else begin
            bit_cnt_next = bit_cnt_reg - CW'(1);
          end
        end
        DATA: begin
          if (bit_cnt_reg == '0) begin
            bit_cnt_next = DIV_LAST;
            if (bit_idx_reg == 3'd7) begin
              txd_next   = 1'b1;
              state_next = STOP;
            end else begin
              bit_idx_next = bit_idx_reg + 3'd1;
              shift_next   = {1'b0, shift_reg[7:1]};
              txd_next     = shift_reg[1];
            end
          end else begin
            bit_cnt_next = bit_cnt_reg - CW'(1);
          end
        end
        STOP: begin
          if (bit_cnt_reg == '0) begin
            state_next = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg - CW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      2'b00:   rd_data = {busy, empty, full, overflow_reg, 4'(count_reg[FIFO_AW-1:0])};
      2'b01:   rd_data = {irq_en_reg, 7'b0};
      default: rd_data = 8'h00;
    endcase
  end

  assign D = (bus.cs && bus.re) ? rd_data : 8'bz;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: writes queue expected bytes, a txd monitor decodes frames
// and compares them, and directed register/line checks cover the corner cases.
module tb_uart_tx_fifo;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  wire  [7:0] D;
  logic [7:0] d_drv = 8'h00;
  logic       d_en = 1'b0;
  logic       txd, uart_tx_irq;

  uart_tx_fifo_if bus();
  assign D = d_en ? d_drv : 8'bz;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(4), .IRQ_THRESH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .D(D), .txd(txd), .uart_tx_irq(uart_tx_irq)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         flush_cnt = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, req);
    end else begin
      $display("ok   %s: 0x%02h", name, act);
    end
  endtask

  // Frame monitor: one frame = 10 bit periods starting at the first low txd.
  int         mon_seen = 0;
  int         idx = 0;
  logic       in_frame = 1'b0;
  logic       cur_bit = 1'b0;
  logic       frame_ok = 1'b0;
  logic [7:0] rx = 8'h00;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (reset || flush_cnt != mon_seen) begin
      mon_seen = flush_cnt;
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (txd == 1'b0) begin
        in_frame = 1'b1; idx = 0; frame_ok = 1'b1; cur_bit = 1'b0; rx = 8'h00;
      end
    end else begin
      idx++;
      if (idx % CLK_DIV == 0) begin
        cur_bit = txd;
        if (idx >= CLK_DIV && idx < 9*CLK_DIV) rx[idx/CLK_DIV-1] = txd;
        if (idx == 9*CLK_DIV && txd !== 1'b1) frame_ok = 1'b0;
      end else if (txd !== cur_bit) begin
        frame_ok = 1'b0;
      end
      if (idx == 10*CLK_DIV-1) begin
        in_frame = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL frame: got 0x%02h, required no frame", rx);
        end else begin
          exp_b = exp_q.pop_front();
          if (rx !== exp_b || !frame_ok) begin
            n_err++;
            $display("FAIL frame: got 0x%02h timing_ok=%0b, required 0x%02h timing_ok=1", rx, frame_ok, exp_b);
          end else begin
            $display("ok   frame: 0x%02h", rx);
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    bus.A = {10'd0, a, 2'b00}; bus.cs = 1'b1; bus.we = 1'b1; d_drv = d; d_en = 1'b1;
    repeat (hold) @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0; d_en = 1'b0;
    $display("write A[3:2]=%0d data=0x%02h hold=%0d", a, d, hold);
  endtask

  task automatic push_byte(input logic [7:0] d, input int hold);
    exp_q.push_back(d);
    bus_write(2'b00, d, hold);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
    bus.A = {10'd0, a, 2'b00}; bus.cs = 1'b1; bus.re = 1'b1;
    #1 v = D;
    bus.cs = 1'b0; bus.re = 1'b0;
    #1;
  endtask

  task automatic check_reg(input string name, input logic [1:0] a, input logic [7:0] req);
    logic [7:0] v;
    bus_read(a, v);
    check(name, v, req);
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic [7:0] s;
    int n = 0;
    bus_read(2'b00, s);
    while (s !== 8'h40 && n < budget) begin
      @(negedge clk); n++;
      bus_read(2'b00, s);
    end
    check(name, s, 8'h40);
  endtask

  initial begin
    logic [7:0] s;
    int lows;
    int n;
    bus.A = '0; bus.cs = 1'b0; bus.re = 1'b0; bus.we = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txd", {7'd0, txd}, 8'h01);
    check("reset_irq", {7'd0, uart_tx_irq}, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    check_reg("reset_status", 2'b00, 8'h40);
    check_reg("reset_ctrl", 2'b01, 8'h00);
    check_reg("reserved_read", 2'b10, 8'h00);
    check_reg("softrst_read", 2'b11, 8'h00);

    // Single byte with write-to-line latency
    push_byte(8'hA5, 1);
    check("latency_pre", {7'd0, txd}, 8'h01);
    check_reg("queued_status", 2'b00, 8'h01);
    @(negedge clk);
    check("latency_start", {7'd0, txd}, 8'h00);
    check_reg("busy_status", 2'b00, 8'hC0);
    wait_idle("single_done", 100);

    bus_write(2'b10, 8'hFF, 1);
    check_reg("reserved_wr_status", 2'b00, 8'h40);
    check_reg("reserved_wr_ctrl", 2'b01, 8'h00);

    // Fill to full behind a long first frame, then overflow
    push_byte(8'h11, 1);
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1);
    check_reg("fill_full", 2'b00, 8'hA0);
    bus_write(2'b00, 8'hEE, 1);
    check_reg("overflow_set", 2'b00, 8'hB0);
    bus_write(2'b01, 8'h01, 1);
    check_reg("overflow_clr", 2'b00, 8'hA0);
    wait_idle("fill_drain", 2000);

    // Long strobe pushes once
    push_byte(8'h3C, 1);
    push_byte(8'hC3, 5);
    check_reg("strobe_count", 2'b00, 8'h81);
    wait_idle("strobe_drain", 200);

    // Interrupt threshold
    bus_write(2'b01, 8'h80, 1);
    @(negedge clk);
    check("irq_empty", {7'd0, uart_tx_irq}, 8'h01);
    check_reg("irq_en_read", 2'b01, 8'h80);
    for (int i = 0; i < 9; i++) push_byte(8'h50 + 8'(i), 1);
    check_reg("irq_count8", 2'b00, 8'h88);
    check("irq_before_drop", {7'd0, uart_tx_irq}, 8'h01);
    @(negedge clk);
    check("irq_drop", {7'd0, uart_tx_irq}, 8'h00);
    n = 0;
    bus_read(2'b00, s);
    while (s[3:0] != 4'd7 && n < 100) begin
      @(negedge clk); n++;
      bus_read(2'b00, s);
    end
    check("count7", s, 8'h87);
    check("irq_still_low", {7'd0, uart_tx_irq}, 8'h00);
    @(negedge clk);
    check("irq_rise", {7'd0, uart_tx_irq}, 8'h01);
    wait_idle("irq_drain", 1000);

    // Soft reset during data bits of a 0x00 frame
    push_byte(8'h00, 1);
    push_byte(8'h5A, 1);
    push_byte(8'h96, 1);
    bus_write(2'b11, 8'h00, 1);
    exp_q.delete();
    flush_cnt++;
    check("softrst_txd", {7'd0, txd}, 8'h01);
    check_reg("softrst_status", 2'b00, 8'h40);
    check_reg("softrst_irqen", 2'b01, 8'h80);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd == 1'b0) lows++;
    end
    check("softrst_quiet", 8'(lows), 8'h00);

    // Asynchronous reset mid-frame
    push_byte(8'h00, 1);
    push_byte(8'h33, 1);
    repeat (6) @(negedge clk);
    check("pre_reset_low", {7'd0, txd}, 8'h00);
    check("pre_reset_irq", {7'd0, uart_tx_irq}, 8'h01);
    #2 reset = 1'b1;
    exp_q.delete();
    flush_cnt++;
    #1;
    check("areset_txd", {7'd0, txd}, 8'h01);
    check("areset_irq", {7'd0, uart_tx_irq}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reg("areset_status", 2'b00, 8'h40);
    check_reg("areset_ctrl", 2'b01, 8'h00);
    repeat (50) @(negedge clk);
    check("areset_quiet", {7'd0, txd}, 8'h01);

    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Host-programmable UART transmitter on the podule byte bus, with a 16-entry transmit FIFO. It is the source end of the `uart_tx_irq` line consumed by the interrupt controller. Host writes bytes through the same `cs`/`re`/`we`/`A`/`D` bus. The block serialises them as 8N1 frames on `txd` and raises `uart_tx_irq` when the FIFO has room for more data.

## Interface
- `CLK_DIV`, 217: clocks per bit period; must be ≥ 2. The default gives 115200 baud at 25 MHz.
- `FIFO_AW`, 4: FIFO address bits; depth = 2^FIFO_AW = 16.
- `IRQ_THRESH`, 8: IRQ is requested while FIFO count < IRQ_THRESH.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `D`  inout  8  host data bus; driven only during register reads, otherwise high-Z.
- `A`  in  14  host address; only A[3:2] are decoded.
- `cs`  in  1  block select, active high.
- `re`  in  1  read strobe, active high.
- `we`  in  1  write strobe, active high.
- `txd`  out  1  serial output; idle high.
- `uart_tx_irq`  out  1  level interrupt request to the interrupt controller.

## Operation
- **Register map (A[3:2]):**
  - 00 write: DATA, pushes D[7:0] into the FIFO.
  - 00 read: STATUS = {busy, empty, full, overflow, count[3:0]}.
  - 01 write: CTRL. D[7] sets irq_en. Writing D[0]=1 clears overflow.
  - 01 read: {irq_en, 7'b0}.
  - 10: reserved. Reads 0x00; writes are ignored.
  - 11 write: soft reset. Flushes the FIFO, aborts any frame in progress, sets `txd`=1, clears overflow. irq_en is unchanged.
  - 11 read: 0x00.
- **Read path:** `D` is driven combinationally while `cs && re`.
- **Write strobes:**
  - The bus is sampled on `clk`. A write takes effect on the first rising edge where `cs && we` is high and was low on the previous edge.
  - A strobe held high for N cycles therefore performs exactly one action.
- **FIFO:**
  - Circular buffer with read pointer, write pointer and count. Count runs 0..16; the pointers wrap modulo 16.
  - empty = (count==0); full = (count==16). STATUS count[3:0] reads 0 when full; the full bit disambiguates.
- **Push while full:** the byte is dropped and the sticky overflow bit is set. The full test uses the count before any same-cycle pop.
- **Push and pop in the same cycle:** both happen; count is unchanged.
- **Transmit FSM:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into the shift register, load the bit counter with CLK_DIV-1, and go to START on the same edge.
  - START: `txd`=0 for CLK_DIV clocks.
  - DATA: 8 bits, LSB first, each held CLK_DIV clocks. A bit index 0..7 advances when the bit counter reaches 0.
  - STOP: `txd`=1 for CLK_DIV clocks, then go to IDLE.
  - The minimum gap between back-to-back frames is one IDLE clock, so the stop bit is effectively CLK_DIV+1 clocks.
- **busy** = (state != IDLE).
- **uart_tx_irq** = irq_en && (count < IRQ_THRESH). It is registered, so it reflects the count one clock after any change.

## Timing
- **Reset values:**
  - State IDLE; FIFO empty; pointers 0.
  - overflow=0; irq_en=0.
  - `txd`=1; `uart_tx_irq`=0; `D` high-Z.
- **Reset mid-frame:** `txd` goes high immediately (asynchronous). The byte in flight is lost.
- **Soft reset mid-frame:** `txd`=1 from the next clock edge.
- **Write to line latency:**
  - DATA write detected at edge E0 → count increments at E0.
  - If IDLE with an empty FIFO, the pop happens at E1 and `txd` falls at E1.
  - The frame ends with return to IDLE at E1 + 10·CLK_DIV.
- **Bit boundaries:** `txd` changes only on clock edges, every CLK_DIV clocks within a frame.
- **Read data:** combinational from current register state; valid throughout `cs && re`.

## Test plan
- **Single byte:** reset, then write 0xA5 to DATA with CLK_DIV=4 → `txd` low for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high. STATUS reads busy=1 during the frame and 0x40 (empty) after.
- **Fill and overflow:**
  - With `txd` stalled behind a long first frame, write 17 bytes → first byte popped, so 16 queued → full=1, overflow=0.
  - An 18th write gives overflow=1. The dropped byte never appears on `txd`.
  - A CTRL write of 0x01 clears overflow.
- **Interrupt threshold:**
  - irq_en=1 with an empty FIFO → `uart_tx_irq`=1.
  - Push 9 bytes (8 queued after the first pop) → irq drops to 0 one clock after count reaches 8.
  - It rises again when count falls to 7.
- **Strobe length:** a DATA write held for 5 cycles → exactly one byte enters the FIFO (count +1).
- **Soft reset mid-frame:** write 3 bytes, then write A[3:2]=11 during DATA bits → `txd`=1 next clock, STATUS=0x40, no further frames.
- **Async reset mid-frame:** assert `reset` between edges while `txd`=0 → `txd`=1 and `uart_tx_irq`=0 immediately; the FIFO is empty after release.
